// File: rtl/spi_mem_ctrl_pkg.sv
// Shared types and constants for the SPI flash/PSRAM controller.
// Frame layout helpers keep the command encoding in one place.
package spi_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    TYPE_IDLE        = 2'd0,
    TYPE_FLASH_READ  = 2'd1,
    TYPE_PSRAM_READ  = 2'd2,
    TYPE_PSRAM_WRITE = 2'd3
  } mem_type_t;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} ctrl_state_t;

  localparam logic [7:0] CMD_READ        = 8'h03;
  localparam logic [7:0] CMD_WRITE       = 8'h02;
  localparam logic [5:0] FLASH_READ_BITS = 6'd48;
  localparam logic [5:0] PSRAM_BITS      = 6'd40;

  // Frames are left-justified so MOSI is always bit 47 of the shifter.
  function automatic logic [47:0] build_frame(mem_type_t t, logic [23:0] a, logic [7:0] wd);
    case (t)
      TYPE_FLASH_READ:  return {CMD_READ, a, 16'h0000};
      TYPE_PSRAM_READ:  return {CMD_READ, a, 16'h0000};
      TYPE_PSRAM_WRITE: return {CMD_WRITE, a, wd, 8'h00};
      default:          return '0;
    endcase
  endfunction

  function automatic logic [5:0] frame_bits(mem_type_t t);
    return (t == TYPE_FLASH_READ) ? FLASH_READ_BITS : PSRAM_BITS;
  endfunction

endpackage

// File: rtl/spi_mem_ctrl_if.sv
// CPU-side request/response bus of the SPI memory controller.
interface spi_mem_ctrl_if;
  import spi_mem_ctrl_pkg::*;

  logic        req_valid_in;
  logic        req_ready_out;
  mem_type_t   req_type_in;
  logic [23:0] req_addr_in;
  logic [7:0]  req_wdata_in;
  logic [15:0] rdata_out;
  logic        done_out;

  modport master (
    output req_valid_in, req_type_in, req_addr_in, req_wdata_in,
    input  req_ready_out, rdata_out, done_out
  );

  modport slave (
    input  req_valid_in, req_type_in, req_addr_in, req_wdata_in,
    output req_ready_out, rdata_out, done_out
  );
endinterface

// File: rtl/spi_half_tick.sv
// Half-period tick generator: one-cycle tick every SCLK_DIV cycles while enabled,
// restarting from zero whenever enable is low.
module spi_half_tick #(
  parameter int SCLK_DIV = 1
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic en_in,
  output logic tick_out
);
  localparam int CW = $clog2(SCLK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(SCLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_in || cnt_q == LAST) cnt_d = '0;
    else                         cnt_d = cnt_q + 1'b1;
  end

  assign tick_out = en_in && (cnt_q == LAST);

  always_ff @(posedge clk_in) begin
    if (reset_in) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI master sequencing single flash-read / PSRAM read / PSRAM write frames
// on a shared mode-0 bus with per-device chip selects.
module spi_mem_ctrl
  import spi_mem_ctrl_pkg::*;
#(
  parameter int SCLK_DIV = 1
) (
  input  logic           clk_in,
  input  logic           reset_in,
  spi_mem_ctrl_if.slave  bus,
  output logic           spi_sclk_out,
  output logic           spi_mosi_out,
  input  logic           spi_miso_in,
  output logic           flash_cs_out,
  output logic           psram_cs_out
);
  ctrl_state_t state_q, state_d;
  mem_type_t   type_q, type_d;
  logic [47:0] sh_q, sh_d;
  logic [5:0]  bitcnt_q, bitcnt_d;
  logic [15:0] rx_q, rx_d, rdata_q, rdata_d;
  logic        done_q, done_d, sclk_q, sclk_d, fcs_q, fcs_d, pcs_q, pcs_d;
  logic        tick, accept;

  spi_half_tick #(.SCLK_DIV(SCLK_DIV)) u_tick (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .en_in    (state_q != IDLE),
    .tick_out (tick)
  );

  assign accept = bus.req_valid_in && (state_q == IDLE) && (bus.req_type_in != TYPE_IDLE);

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    sh_d     = sh_q;
    bitcnt_d = bitcnt_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    sclk_d   = sclk_q;
    fcs_d    = fcs_q;
    pcs_d    = pcs_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d  = SETUP;
        type_d   = bus.req_type_in;
        sh_d     = build_frame(bus.req_type_in, bus.req_addr_in, bus.req_wdata_in);
        bitcnt_d = '0;
        rx_d     = '0;
        sclk_d   = 1'b0;
        fcs_d    = (bus.req_type_in != TYPE_FLASH_READ);
        pcs_d    = (bus.req_type_in == TYPE_FLASH_READ);
      end
      SETUP: if (tick) begin
        sclk_d  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (tick) begin
        if (bitcnt_q == frame_bits(type_q)) begin
          // CS hold after the last fall has elapsed: release and report.
          state_d = GAP;
          fcs_d   = 1'b1;
          pcs_d   = 1'b1;
          done_d  = 1'b1;
          if (type_q == TYPE_FLASH_READ)      rdata_d = {rx_q[7:0], rx_q[15:8]};
          else if (type_q == TYPE_PSRAM_READ) rdata_d = {8'h00, rx_q[7:0]};
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d   = 1'b0;
          sh_d     = {sh_q[46:0], 1'b0};
          bitcnt_d = bitcnt_q + 6'd1;
          if (bitcnt_q >= 6'd32) rx_d = {rx_q[14:0], spi_miso_in};
        end
      end
      GAP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q  <= IDLE;
      type_q   <= TYPE_IDLE;
      sh_q     <= '0;
      bitcnt_q <= '0;
      rx_q     <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      fcs_q    <= 1'b1;
      pcs_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      sh_q     <= sh_d;
      bitcnt_q <= bitcnt_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      fcs_q    <= fcs_d;
      pcs_q    <= pcs_d;
    end
  end

  assign bus.req_ready_out = (state_q == IDLE);
  assign bus.rdata_out     = rdata_q;
  assign bus.done_out      = done_q;
  assign spi_sclk_out      = sclk_q;
  assign spi_mosi_out      = sh_q[47];
  assign flash_cs_out      = fcs_q;
  assign psram_cs_out      = pcs_q;
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench: two controllers (D=1, D=3) share one flash/PSRAM slave model via a select mux.
`timescale 1ns/1ps
module tb_spi_mem_ctrl;
  import spi_mem_ctrl_pkg::*;

  logic clk_in = 1'b0;
  logic reset_in = 1'b1;
  always #5 clk_in = ~clk_in;

  spi_mem_ctrl_if bus1();
  spi_mem_ctrl_if bus3();

  logic sclk1, mosi1, fcs1, pcs1, sclk3, mosi3, fcs3, pcs3;
  logic miso = 1'b0;
  logic sel = 1'b0;

  spi_mem_ctrl #(.SCLK_DIV(1)) u_d1 (
    .clk_in(clk_in), .reset_in(reset_in), .bus(bus1.slave),
    .spi_sclk_out(sclk1), .spi_mosi_out(mosi1), .spi_miso_in(miso),
    .flash_cs_out(fcs1), .psram_cs_out(pcs1)
  );
  spi_mem_ctrl #(.SCLK_DIV(3)) u_d3 (
    .clk_in(clk_in), .reset_in(reset_in), .bus(bus3.slave),
    .spi_sclk_out(sclk3), .spi_mosi_out(mosi3), .spi_miso_in(miso),
    .flash_cs_out(fcs3), .psram_cs_out(pcs3)
  );

  logic        sclk_m, mosi_m, fcs_m, pcs_m, ready_m, done_m;
  logic [15:0] rdata_m;
  assign sclk_m  = sel ? sclk3 : sclk1;
  assign mosi_m  = sel ? mosi3 : mosi1;
  assign fcs_m   = sel ? fcs3 : fcs1;
  assign pcs_m   = sel ? pcs3 : pcs1;
  assign ready_m = sel ? bus3.req_ready_out : bus1.req_ready_out;
  assign done_m  = sel ? bus3.done_out : bus1.done_out;
  assign rdata_m = sel ? bus3.rdata_out : bus1.rdata_out;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Slave model: captures MOSI on rising SCLK, shifts MISO on falling SCLK.
  logic [7:0]  flash_mem [256];
  logic [7:0]  psram_mem [256];
  int          mcnt = 0;
  logic [47:0] mrx = '0;
  logic [15:0] mout = '0;

  always @(posedge sclk_m or negedge fcs_m or negedge pcs_m) begin
    if (!sclk_m) begin
      mcnt = 0;
      mrx  = '0;
    end else if (!fcs_m || !pcs_m) begin
      mrx  = {mrx[46:0], mosi_m};
      mcnt = mcnt + 1;
      if (mcnt == 40 && !pcs_m && mrx[39:32] == 8'h02) psram_mem[mrx[15:8]] = mrx[7:0];
    end
  end

  always @(negedge sclk_m) begin
    if (!fcs_m || !pcs_m) begin
      if (mcnt == 32)
        mout = !fcs_m ? {flash_mem[mrx[7:0]], flash_mem[mrx[7:0] + 8'd1]}
                      : {psram_mem[mrx[7:0]], 8'h00};
      else
        mout = {mout[14:0], 1'b0};
      #1 miso = mout[15];
    end
  end

  task automatic drive(input bit v, input mem_type_t t, input logic [23:0] a, input logic [7:0] wd);
    bus1.req_valid_in = v && !sel;
    bus3.req_valid_in = v && sel;
    bus1.req_type_in  = t;
    bus3.req_type_in  = t;
    bus1.req_addr_in  = a;
    bus3.req_addr_in  = a;
    bus1.req_wdata_in = wd;
    bus3.req_wdata_in = wd;
  endtask

  // One request from IDLE; returns done latency, rdata at done, CS-low counts and SCLK phase stats.
  task automatic run_txn(input mem_type_t t, input logic [23:0] a, input logic [7:0] wd, input int d,
                         output int lat, output logic [15:0] rd, output int fcs_low, output int pcs_low,
                         output int hi_runs, output int bad_runs);
    int e0, run;
    logic prev;
    lat = -1; rd = '0; fcs_low = 0; pcs_low = 0; hi_runs = 0; bad_runs = 0; run = 0; prev = 1'b0;
    @(negedge clk_in); drive(1'b1, t, a, wd);
    @(posedge clk_in); #1 e0 = cyc;
    @(negedge clk_in); drive(1'b0, TYPE_IDLE, 24'h0, 8'h0);
    for (int i = 0; i < 2000; i++) begin
      if (done_m) begin
        lat = cyc - e0;
        rd  = rdata_m;
        if (run != d) bad_runs++;
        break;
      end
      if (!fcs_m) fcs_low++;
      if (!pcs_m) pcs_low++;
      if (i == 0) begin
        prev = sclk_m; run = 1;
      end else if (sclk_m == prev) begin
        run++;
      end else begin
        if (prev) hi_runs++;
        if (run != d) bad_runs++;
        prev = sclk_m; run = 1;
      end
      @(negedge clk_in);
    end
    for (int i = 0; i < 100 && !ready_m; i++) @(negedge clk_in);
  endtask

  task automatic test_reset();
    sel = 1'b0;
    drive(1'b0, TYPE_IDLE, 24'h0, 8'h0);
    reset_in = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    tests++; if (bus1.req_ready_out !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", bus1.req_ready_out); end
    tests++; if (bus1.done_out !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus1.done_out); end
    tests++; if (bus1.rdata_out !== 16'h0000) begin fails++; $display("FAIL reset_rdata: got %h want 0000", bus1.rdata_out); end
    tests++; if ({sclk1, mosi1} !== 2'b00) begin fails++; $display("FAIL reset_sclk_mosi: got %b want 00", {sclk1, mosi1}); end
    tests++; if ({fcs1, pcs1, fcs3, pcs3} !== 4'b1111) begin fails++; $display("FAIL reset_cs: got %b want 1111", {fcs1, pcs1, fcs3, pcs3}); end
    reset_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_flash_read();
    int lat, fl, pl, hr, br;
    logic [15:0] rd;
    sel = 1'b0;
    run_txn(TYPE_FLASH_READ, 24'h000010, 8'h00, 1, lat, rd, fl, pl, hr, br);
    tests++; if (lat !== 97) begin fails++; $display("FAIL flash_latency: got %0d want 97", lat); end
    tests++; if (rd !== 16'h3CA5) begin fails++; $display("FAIL flash_rdata: got %h want 3ca5", rd); end
    tests++; if (pl !== 0 || fl !== 97) begin fails++; $display("FAIL flash_cs: flash low %0d psram low %0d want 97/0", fl, pl); end
    tests++; if (hr !== 48 || br !== 0) begin fails++; $display("FAIL flash_sclk: highs %0d bad %0d want 48/0", hr, br); end
    tests++; if (bus1.rdata_out !== 16'h3CA5) begin fails++; $display("FAIL flash_rdata_hold: got %h want 3ca5", bus1.rdata_out); end
  endtask

  task automatic test_psram_write_read();
    int lat, fl, pl, hr, br;
    logic [15:0] rd;
    sel = 1'b0;
    run_txn(TYPE_PSRAM_WRITE, 24'h000020, 8'h5A, 1, lat, rd, fl, pl, hr, br);
    tests++; if (lat !== 81) begin fails++; $display("FAIL pwrite_latency: got %0d want 81", lat); end
    tests++; if (rd !== 16'h3CA5) begin fails++; $display("FAIL pwrite_rdata_kept: got %h want 3ca5", rd); end
    tests++; if (fl !== 0 || pl !== 81) begin fails++; $display("FAIL pwrite_cs: flash low %0d psram low %0d want 0/81", fl, pl); end
    run_txn(TYPE_PSRAM_READ, 24'h000020, 8'h00, 1, lat, rd, fl, pl, hr, br);
    tests++; if (lat !== 81) begin fails++; $display("FAIL pread_latency: got %0d want 81", lat); end
    tests++; if (rd !== 16'h005A) begin fails++; $display("FAIL pread_rdata: got %h want 005a", rd); end
    tests++; if (fl !== 0 || hr !== 40 || br !== 0) begin fails++; $display("FAIL pread_bus: flash low %0d highs %0d bad %0d want 0/40/0", fl, hr, br); end
  endtask

  task automatic test_back_to_back();
    int e0, acc2, d1, d2, ndone, rdy_low, cs_gap;
    logic [15:0] rd2;
    sel = 1'b0; acc2 = -1; d1 = -1; d2 = -1; ndone = 0; rdy_low = 0; cs_gap = 0; rd2 = '0;
    @(negedge clk_in); drive(1'b1, TYPE_PSRAM_WRITE, 24'h000030, 8'hC3);
    @(posedge clk_in); #1 e0 = cyc;
    @(negedge clk_in); drive(1'b1, TYPE_PSRAM_READ, 24'h000030, 8'h00);
    for (int i = 0; i < 400; i++) begin
      if (done_m) begin
        ndone++;
        if (ndone == 1) d1 = cyc - e0;
        else begin d2 = cyc - e0; rd2 = rdata_m; break; end
      end
      if (acc2 < 0) begin
        if (ndone == 1 && pcs_m) cs_gap++;
        if (ready_m) acc2 = cyc + 1 - e0;
        else rdy_low++;
      end else if (bus1.req_valid_in) begin
        drive(1'b0, TYPE_IDLE, 24'h0, 8'h0);
      end
      @(negedge clk_in);
    end
    drive(1'b0, TYPE_IDLE, 24'h0, 8'h0);
    tests++; if (d1 !== 81) begin fails++; $display("FAIL b2b_done1: got %0d want 81", d1); end
    tests++; if (rdy_low !== 82 || acc2 !== 83) begin fails++; $display("FAIL b2b_ready: low %0d accept %0d want 82/83", rdy_low, acc2); end
    tests++; if (cs_gap < 1) begin fails++; $display("FAIL b2b_cs_gap: got %0d want >=1", cs_gap); end
    tests++; if (d2 !== 164 || rd2 !== 16'h00C3) begin fails++; $display("FAIL b2b_second: done %0d rdata %h want 164/00c3", d2, rd2); end
    for (int i = 0; i < 100 && !ready_m; i++) @(negedge clk_in);
  endtask

  task automatic test_reset_mid();
    int e0, seen_done, lat, fl, pl, hr, br;
    logic [15:0] rd;
    sel = 1'b0; seen_done = 0;
    @(negedge clk_in); drive(1'b1, TYPE_FLASH_READ, 24'h000010, 8'h00);
    @(posedge clk_in); #1 e0 = cyc;
    @(negedge clk_in); drive(1'b0, TYPE_IDLE, 24'h0, 8'h0);
    for (int i = 0; i < 100 && cyc < e0 + 29; i++) begin
      if (done_m) seen_done++;
      @(negedge clk_in);
    end
    tests++; if (fcs1 !== 1'b0) begin fails++; $display("FAIL rstmid_active: flash cs %b want 0", fcs1); end
    reset_in = 1'b1;
    @(negedge clk_in);
    if (done_m) seen_done++;
    tests++; if ({fcs1, pcs1, sclk1, bus1.req_ready_out} !== 4'b1101) begin fails++; $display("FAIL rstmid_state: fcs,pcs,sclk,ready %b want 1101", {fcs1, pcs1, sclk1, bus1.req_ready_out}); end
    tests++; if (seen_done !== 0 || bus1.rdata_out !== 16'h0000) begin fails++; $display("FAIL rstmid_done_rdata: dones %0d rdata %h want 0/0000", seen_done, bus1.rdata_out); end
    reset_in = 1'b0;
    @(negedge clk_in);
    run_txn(TYPE_PSRAM_READ, 24'h000020, 8'h00, 1, lat, rd, fl, pl, hr, br);
    tests++; if (lat !== 81 || rd !== 16'h005A) begin fails++; $display("FAIL rstmid_next_read: lat %0d rdata %h want 81/005a", lat, rd); end
  endtask

  task automatic test_idle_type();
    int rdy_low, cs_low, dones;
    sel = 1'b0; rdy_low = 0; cs_low = 0; dones = 0;
    @(negedge clk_in); drive(1'b1, TYPE_IDLE, 24'h000010, 8'h77);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (!ready_m) rdy_low++;
      if (!fcs_m || !pcs_m || sclk_m) cs_low++;
      if (done_m) dones++;
    end
    drive(1'b0, TYPE_IDLE, 24'h0, 8'h0);
    tests++; if (rdy_low !== 0) begin fails++; $display("FAIL idle_ready: low cycles %0d want 0", rdy_low); end
    tests++; if (cs_low !== 0) begin fails++; $display("FAIL idle_bus: active cycles %0d want 0", cs_low); end
    tests++; if (dones !== 0) begin fails++; $display("FAIL idle_done: pulses %0d want 0", dones); end
  endtask

  task automatic test_div3();
    int lat, fl, pl, hr, br;
    logic [15:0] rd;
    sel = 1'b1;
    run_txn(TYPE_FLASH_READ, 24'h000010, 8'h00, 3, lat, rd, fl, pl, hr, br);
    tests++; if (lat !== 291) begin fails++; $display("FAIL d3_latency: got %0d want 291", lat); end
    tests++; if (rd !== 16'h3CA5) begin fails++; $display("FAIL d3_rdata: got %h want 3ca5", rd); end
    tests++; if (fl !== 291 || pl !== 0) begin fails++; $display("FAIL d3_cs: flash low %0d psram low %0d want 291/0", fl, pl); end
    tests++; if (hr !== 48 || br !== 0) begin fails++; $display("FAIL d3_sclk_phase: highs %0d bad %0d want 48/0", hr, br); end
    sel = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) flash_mem[i] = 8'(i ^ 8'h5C);
    flash_mem[8'h10] = 8'hA5;
    flash_mem[8'h11] = 8'h3C;
    test_reset();
    test_flash_read();
    test_psram_write_read();
    test_back_to_back();
    test_reset_mid();
    test_idle_type();
    test_div3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
